// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: FSM encoding and AES size constants shared by the round sequencer.
package aes_seq_pkg;
    typedef enum logic [1:0] {IDLE, KEY0, ROUND, DONE} seq_state_t;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;
    localparam int DW = 128;
endpackage

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES round controller driving an external round
// datapath and key-expansion unit, with valid/ready block input and output.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int DW    = aes_seq_pkg::DW,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             rk_req,
    output logic [CNT_W-1:0] rk_idx,
    input  logic             rk_valid,
    input  logic [DW-1:0]    rk_data,
    output logic [DW-1:0]    dp_state,
    output logic [DW-1:0]    dp_rk,
    output logic             dp_last,
    input  logic [DW-1:0]    dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             busy
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NR);

    seq_state_t       st;
    logic [CNT_W-1:0] round;
    logic [DW-1:0]    state_q;

    assign dp_state = state_q;
    assign dp_rk    = rk_data;
    assign out_data = state_q;

    // Handshake outputs are registered from the next state, so each branch sets them directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            round     <= '0;
            state_q   <= '0;
            in_ready  <= 1'b0;
            rk_req    <= 1'b0;
            rk_idx    <= '0;
            dp_last   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            st        <= IDLE;
            round     <= '0;
            in_ready  <= 1'b1;
            rk_req    <= 1'b0;
            rk_idx    <= '0;
            dp_last   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    in_ready <= !(in_valid && in_ready);
                    if (in_valid && in_ready) begin
                        st      <= KEY0;
                        state_q <= in_data;
                        rk_req  <= 1'b1;
                        rk_idx  <= '0;
                        busy    <= 1'b1;
                    end
                end
                KEY0: if (rk_valid) begin
                    st      <= ROUND;
                    state_q <= state_q ^ rk_data;
                    round   <= CNT_W'(1);
                    rk_idx  <= CNT_W'(1);
                    dp_last <= (NR == 1);
                end
                ROUND: if (rk_valid) begin
                    state_q <= dp_result;
                    if (round == LAST) begin
                        st        <= DONE;
                        rk_req    <= 1'b0;
                        dp_last   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        round   <= round + 1'b1;
                        rk_idx  <= round + 1'b1;
                        dp_last <= (round + 1'b1 == LAST);
                    end
                end
                DONE: if (out_ready) begin
                    st        <= IDLE;
                    round     <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: AES-128 and AES-256 sequencers against FIPS-197 vectors,
// with the bench acting as key-expansion unit and combinational round datapath.
module tb_aes_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic in_valid[2], in_ready[2], rk_req[2], rk_valid[2], dp_last[2];
    logic out_valid[2], out_ready[2], busy[2];
    logic [127:0] in_data[2], rk_data[2], dp_state[2], dp_rk[2], dp_result[2], out_data[2];
    logic [3:0] rk_idx[2];
    logic [7:0] sb[256];
    logic [127:0] rk_tab[2][15];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10)) u_a128 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .rk_req(rk_req[0]), .rk_idx(rk_idx[0]), .rk_valid(rk_valid[0]), .rk_data(rk_data[0]),
        .dp_state(dp_state[0]), .dp_rk(dp_rk[0]), .dp_last(dp_last[0]), .dp_result(dp_result[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    aes_round_sequencer #(.NR(14)) u_a256 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .rk_req(rk_req[1]), .rk_idx(rk_idx[1]), .rk_valid(rk_valid[1]), .rk_data(rk_data[1]),
        .dp_state(dp_state[1]), .dp_rk(dp_rk[1]), .dp_last(dp_last[1]), .dp_result(dp_result[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse (a^254) and the affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk, input logic last);
        logic [7:0] b[16], t[16], m[16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sb[st[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
            m[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = last ? t[i] : m[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] model_enc(input int s, input logic [127:0] pt, input int nr);
        logic [127:0] x = pt ^ rk_tab[s][0];
        for (int r = 1; r <= nr; r++) x = aes_round(x, rk_tab[s][r], r == nr);
        return x;
    endfunction

    task automatic set_key(input int s, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w[60];
        logic [31:0] tmp;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
            w[i] = w[i-nk] ^ tmp;
        end
        for (int k = 0; k <= nr; k++) rk_tab[s][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    assign rk_data[0]   = rk_tab[0][rk_idx[0]];
    assign rk_data[1]   = rk_tab[1][rk_idx[1]];
    assign dp_result[0] = aes_round(dp_state[0], dp_rk[0], dp_last[0]);
    assign dp_result[1] = aes_round(dp_state[1], dp_rk[1], dp_last[1]);

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic accept(input int s, input logic [127:0] pt, input string nm);
        int w = 0;
        while (!in_ready[s] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " in_ready"}, 136'(in_ready[s]), 136'(1));
        in_valid[s] = 1'b1;
        in_data[s] = pt;
        @(negedge clk);
        in_valid[s] = 1'b0;
        in_data[s] = '0;
    endtask

    task automatic run_block(input int s, input logic [127:0] pt, input logic [127:0] exp, input int exp_lat,
                             input int st_rnd, input int st_n, input int bp_n, input string nm);
        int cyc = 1;
        int stalled = 0;
        out_ready[s] = (bp_n == 0);
        accept(s, pt, nm);
        while (!out_valid[s] && cyc < 100) begin
            if (rk_req[s] && rk_idx[s] == st_rnd && stalled < st_n) begin
                rk_valid[s] = 1'b0;
                chk({nm, " stall idx"}, 136'(rk_idx[s]), 136'(st_rnd));
                stalled++;
            end else rk_valid[s] = 1'b1;
            @(negedge clk);
            cyc++;
        end
        rk_valid[s] = 1'b1;
        chk({nm, " latency"}, 136'(cyc), 136'(exp_lat));
        chk({nm, " data"}, 136'(out_data[s]), 136'(exp));
        for (int i = 0; i < bp_n; i++) begin
            @(negedge clk);
            chk({nm, " bp hold"}, {6'd0, out_valid[s], in_ready[s], out_data[s]}, {6'd0, 1'b1, 1'b0, exp});
        end
        out_ready[s] = 1'b1;
        @(negedge clk);
        chk({nm, " post"}, 136'({out_valid[s], busy[s], in_ready[s]}), 136'(3'b001));
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int w, seen;
        logic [127:0] k128, pt_c, ct_c;
        logic [127:0] pt2, exp2;
        k128 = 128'h000102030405060708090a0b0c0d0e0f;
        pt_c = 128'h00112233445566778899aabbccddeeff;
        ct_c = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vecs[0] = '{k128, pt_c, ct_c};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0;
            in_data[s] = '0;
            rk_valid[s] = 1'b1;
            out_ready[s] = 1'b1;
        end
        set_key(0, {k128, 128'h0}, 4, 10);
        set_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++)
            chk("reset outputs", {in_ready[s], rk_req[s], busy[s], out_valid[s], dp_last[s], rk_idx[s], out_data[s]},
                136'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", 136'({in_ready[0], in_ready[1], busy[0], busy[1]}), 136'(4'b1100));

        flush = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0] = pt_c;
        @(negedge clk);
        flush = 1'b0;
        in_valid[0] = 1'b0;
        chk("flush in idle no accept", 136'({busy[0], in_ready[0]}), 136'(2'b01));

        for (int i = 0; i < 4; i++) begin
            set_key(0, {vecs[i].key, 128'h0}, 4, 10);
            run_block(0, vecs[i].pt, vecs[i].ct, 12, -1, 0, 0, $sformatf("vec%0d", i));
        end
        set_key(0, {k128, 128'h0}, 4, 10);

        run_block(0, pt_c, ct_c, 15, 5, 3, 0, "stall r5");
        run_block(0, pt_c, ct_c, 12, -1, 0, 4, "backpressure");

        accept(0, pt_c, "flush blk");
        w = 0;
        while (!(rk_req[0] && rk_idx[0] == 4'd7) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("flush reach r7", 136'(rk_idx[0]), 136'(7));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush to idle", 136'({busy[0], rk_req[0], out_valid[0], in_ready[0]}), 136'(4'b0001));
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1;
        end
        chk("flush no output", 136'(seen), 136'(0));
        run_block(0, pt_c, ct_c, 12, -1, 0, 0, "after flush");

        accept(0, pt_c, "reset blk");
        w = 0;
        while (!(rk_req[0] && rk_idx[0] == 4'd3) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("reset reach r3", 136'(rk_idx[0]), 136'(3));
        rst_n = 1'b0;
        #1;
        chk("reset mid-block", {in_ready[0], rk_req[0], busy[0], out_valid[0], dp_last[0], rk_idx[0], out_data[0]},
            136'h0);
        @(negedge clk);
        chk("in_ready held in reset", 136'(in_ready[0]), 136'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after release", 136'({in_ready[0], busy[0], out_valid[0]}), 136'(3'b100));

        pt2 = 128'h3243f6a8885a308d313198a2e0370734;
        exp2 = model_enc(1, pt2, 14);
        run_block(1, pt_c, 128'h8ea2b7ca516745bfeafc49904b496089, 16, -1, 0, 0, "aes256 a");
        run_block(1, pt2, exp2, 16, -1, 0, 0, "aes256 b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
